// File: rtl/sign_narrow_pkg.sv
// Shared types and helpers for the 32->8 bit signed narrowing block.
// Saturation is selected in sign_narrow by the SIGN_NARROW_SAT_EN macro.
package sign_narrow_pkg;

    localparam logic [7:0] SAT_MAX = 8'h7F;
    localparam logic [7:0] SAT_MIN = 8'h80;

    typedef struct packed {
        logic [7:0] data;
        logic       ovf;
    } narrow_t;

    // A word fits in int8 only when bits 31..7 are a pure sign extension.
    function automatic logic is_out_of_range(input logic [31:0] w);
        return !((&w[31:7]) || !(|w[31:7]));
    endfunction

endpackage

// File: rtl/sign_narrow_skid_buf.sv
// Two-entry valid/ready buffer: a main output register plus a skid register.
// Ready is registered and simply means the skid register is empty.
module skid_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         ready_i
);

    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         main_vld_q, main_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic         in_fire;

    assign ready_o = ~skid_vld_q;
    assign valid_o = main_vld_q;
    assign data_o  = main_q;
    assign in_fire = valid_i & ~skid_vld_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!main_vld_q || ready_i) begin
            // Main slot is free or draining: refill from skid first to keep order.
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = in_fire;
                if (in_fire) main_d = data_i;
            end
        end else if (in_fire) begin
            skid_d     = data_i;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

endmodule

// File: rtl/sign_narrow.sv
// Narrows signed 32-bit words to int8 with overflow flag and statistics.
// Define SIGN_NARROW_SAT_EN to saturate out-of-range words instead of wrapping.
module sign_narrow
    import sign_narrow_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_ovf,
    input  logic             out_ready,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] ovf_count,
    output logic             ovf_sticky
);

    narrow_t              nw_in, nw_out;
    logic [$bits(narrow_t)-1:0] pl_in, pl_out;
    logic                 in_fire;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;

    always_comb begin
        nw_in.ovf  = is_out_of_range(in_data);
        nw_in.data = in_data[7:0];
`ifdef SIGN_NARROW_SAT_EN
        if (nw_in.ovf) nw_in.data = in_data[31] ? SAT_MIN : SAT_MAX;
`endif
    end

    assign pl_in = nw_in;

    skid_buf #(.W($bits(narrow_t))) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (in_valid),
        .data_i  (pl_in),
        .ready_o (in_ready),
        .valid_o (out_valid),
        .data_o  (pl_out),
        .ready_i (out_ready)
    );

    assign nw_out   = narrow_t'(pl_out);
    assign out_data = nw_out.data;
    assign out_ovf  = nw_out.ovf;

    // Overflows are counted when the word is accepted, not when it leaves.
    assign in_fire = in_valid & in_ready;

    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clr_stats) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (in_fire && nw_in.ovf) begin
            sticky_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign ovf_count  = cnt_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_sign_narrow.sv
// Randomised and directed bench for sign_narrow against a queue-based reference model.
// Expectations follow SIGN_NARROW_SAT_EN the same way as the design build.
module tb_sign_narrow;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ovf;
    logic             out_ready = 1'b0;
    logic             clr_stats = 1'b0;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_sticky;

    always #5 clk = ~clk;

    sign_narrow #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .out_ready  (out_ready),
        .clr_stats  (clr_stats),
        .ovf_count  (ovf_count),
        .ovf_sticky (ovf_sticky)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: FIFO of {data, ovf} results held in the block (max 2).
    logic [8:0] m_q[$];
    int         m_cnt = 0;
    logic       m_sticky = 1'b0;
    logic       m_rst_seen = 1'b1;
    logic       m_in_fire = 1'b0;
    int         m_popped = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_narrow(input logic [31:0] d);
        int s;
        logic ovf;
        logic [7:0] r;
        s   = $signed(d);
        ovf = (s > 127) || (s < -128);
        r   = d[7:0];
`ifdef SIGN_NARROW_SAT_EN
        if (ovf) r = (s < 0) ? 8'h80 : 8'h7F;
`endif
        return {r, ovf};
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(m_q[0][8:1]));
            chk("out_ovf", 32'(out_ovf), 32'(m_q[0][0]));
        end else if (m_rst_seen) begin
            chk("rst_out_data", 32'(out_data), 32'd0);
            chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        end
        chk("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
        chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
        chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
    endtask

    // One clock cycle: check state at negedge, drive inputs, advance model at posedge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic ordy,
                       input logic clr, input logic rs);
        logic [8:0] nw;
        logic       out_fire;
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clr_stats = clr;
        rst_n     = rs;
        @(posedge clk);
        nw = ref_narrow(d);
        m_in_fire = 1'b0;
        if (!rs) begin
            m_q.delete();
            m_cnt      = 0;
            m_sticky   = 1'b0;
            m_rst_seen = 1'b1;
        end else begin
            m_in_fire = v && (m_q.size() < 2);
            out_fire  = ordy && (m_q.size() != 0);
            if (clr) begin
                m_cnt    = 0;
                m_sticky = 1'b0;
            end else if (m_in_fire && nw[0]) begin
                m_sticky = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
            if (out_fire) begin
                void'(m_q.pop_front());
                m_popped++;
            end
            if (m_in_fire) begin
                m_q.push_back(nw);
                m_rst_seen = 1'b0;
            end
        end
    endtask

    initial begin
        int w;
        int c;
        logic stalled;
        int s;
        logic [31:0] d;

        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1);

        // In-range words pass through unchanged.
        cyc(1, 32'hFFFFFFE2, 1, 0, 1);
        #1 chk("neg30_data", 32'(out_data), 32'hE2);
        cyc(1, 32'h00000028, 1, 0, 1);
        #1 chk("pos40_data", 32'(out_data), 32'h28);
        chk("pos40_cnt", 32'(ovf_count), 32'd0);

        cyc(1, 32'h0000012C, 1, 0, 1);
        #1 chk("p300_ovf", 32'(out_ovf), 32'd1);
`ifdef SIGN_NARROW_SAT_EN
        chk("p300_data", 32'(out_data), 32'h7F);
`else
        chk("p300_data", 32'(out_data), 32'h2C);
`endif
        chk("p300_sticky", 32'(ovf_sticky), 32'd1);
        chk("p300_cnt", 32'(ovf_count), 32'd1);

        cyc(1, 32'hFFFFFF38, 1, 0, 1);
        #1 chk("n200_ovf", 32'(out_ovf), 32'd1);
`ifdef SIGN_NARROW_SAT_EN
        chk("n200_data", 32'(out_data), 32'h80);
`else
        chk("n200_data", 32'(out_data), 32'h38);
`endif
        cyc(1, 32'hFFFFFF80, 1, 0, 1);
        #1 chk("n128_data", 32'(out_data), 32'h80);
        chk("n128_ovf", 32'(out_ovf), 32'd0);
        cyc(0, 0, 1, 0, 1);

        // Backpressure: words 1..10, out_ready low for cycles 3..7.
        m_popped = 0;
        w = 1;
        stalled = 1'b0;
        for (c = 1; c <= 40 && (w <= 10 || m_q.size() != 0); c++) begin
            if (in_ready == 1'b0) stalled = 1'b1;
            cyc(w <= 10, 32'(w), !(c >= 3 && c <= 7), 0, 1);
            if (m_in_fire) w++;
        end
        chk("bp_words_in", 32'(w - 1), 32'd10);
        chk("bp_words_out", 32'(m_popped), 32'd10);
        chk("bp_stalled", 32'(stalled), 32'd1);

        // Counter saturation and clear-wins.
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 32'd1000 + 32'(i), 1, 0, 1);
        cyc(0, 0, 1, 0, 1);
        #1 chk("sat_cnt", 32'(ovf_count), 32'(CNT_MAX));
        cyc(1, 32'd5000, 1, 1, 1);
        #1 chk("clr_cnt", 32'(ovf_count), 32'd0);
        chk("clr_sticky", 32'(ovf_sticky), 32'd0);

        // Reset with two words buffered.
        cyc(1, 32'd11, 0, 0, 1);
        cyc(1, 32'hFFFF0000, 0, 0, 1);
        cyc(1, 32'd13, 0, 0, 1);
        chk("pre_rst_ready", 32'(in_ready), 32'd0);
        cyc(0, 0, 1, 0, 0);
        #1 chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_cnt", 32'(ovf_count), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: d = $urandom;
                1: begin s = int'($urandom_range(0, 300)) - 150; d = 32'(s); end
                2: begin s = int'($urandom_range(0, 6)) - 3; d = 32'(s + (($urandom_range(0, 1) != 0) ? 127 : -128)); end
                default: d = 32'($urandom_range(0, 255));
            endcase
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0,
                $urandom_range(0, 31) == 0, $urandom_range(0, 99) != 0);
        end
        @(negedge clk);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sign_narrow.md
SIGN_NARROW -- requirements
Module: sign_narrow

Interface
REQ-001 Parameter CNT_W, default 16: width of the overflow event counter; legal range 4..32.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_data  input  32  signed two's-complement word to narrow.
REQ-006 in_ready  output  1  block can accept a word this cycle; registered.
REQ-007 out_valid  output  1  narrowed result valid.
REQ-008 out_data  output  8  signed narrowed result.
REQ-009 out_ovf  output  1  this result was out of the signed 8-bit range.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 clr_stats  input  1  synchronous clear of ovf_count and ovf_sticky.
REQ-012 ovf_count  output  CNT_W  saturating count of accepted out-of-range words.
REQ-013 ovf_sticky  output  1  set by any accepted out-of-range word; held until clr_stats or reset.

Function
REQ-014 Transfer in: in_valid and in_ready high at a rising edge; transfer out: out_valid and out_ready high at a rising edge.
REQ-015 Out-of-range: in_data[31:7] not all equal.
REQ-016 In-range word: out_data = in_data[7:0], out_ovf = 0.
REQ-017 Latency: an accepted word appears on out_valid on the next cycle when the output stage is empty or draining; order is strictly preserved.
REQ-018 Buffering: 2-entry skid (main and skid register); in_ready = skid register empty; full throughput of 1 word/cycle when out_ready is held high.
REQ-019 When out_ready is low and out_valid is high, out_data and out_ovf stay stable until transferred.
REQ-020 Simultaneous in and out transfers in the same cycle neither lose nor duplicate a word.
REQ-021 ovf_count increments by 1 per out-of-range word, counted at input transfer; it holds at all-ones and never wraps.
REQ-022 When clr_stats and a counted input transfer occur in the same cycle, the clear wins: ovf_count = 0 and ovf_sticky = 0.
REQ-023 in_valid high while in_ready is low has no effect; the upstream holds the word.

Reset
REQ-024 With rst_n low at a rising edge: out_valid = 0, in_ready = 1 on the following cycle, out_data = 0, out_ovf = 0, ovf_count = 0, ovf_sticky = 0.
REQ-025 Reset mid-operation discards all buffered words without emitting them.
REQ-026 Inputs are ignored during the cycle rst_n is low.

Configuration
REQ-027 Macro SIGN_NARROW_SAT_EN defined: out-of-range words saturate: out_data = 8'h80 if in_data[31] = 1, else 8'h7F.
REQ-028 Macro SIGN_NARROW_SAT_EN undefined: out-of-range words wrap: out_data = in_data[7:0].
REQ-029 out_ovf, ovf_count and ovf_sticky behave identically with or without the macro.

Structure
REQ-030 Package sign_narrow_pkg holds:
  - constants SAT_MAX = 8'h7F and SAT_MIN = 8'h80;
  - the narrowed-word struct {data[7:0], ovf};
  - the out-of-range detect function.
REQ-031 Sub-module skid_buf implements the 2-entry valid/ready buffer, parameterised on payload width (9 bits here).
REQ-032 Range detect and saturate/wrap logic are combinational ahead of skid_buf; statistics logic lives in the top module.

Verification
REQ-033 Inputs 32'hFFFFFFE2 (-30), then 32'h00000028 (40), with out_ready = 1 -> out_data 8'hE2, then 8'h28; out_ovf = 0 for both; ovf_count = 0.
REQ-034 Input 32'h0000012C (300) -> out_ovf = 1, out_data = 8'h7F with SIGN_NARROW_SAT_EN, 8'h2C without; ovf_sticky = 1; ovf_count = 1.
REQ-035 Input 32'hFFFFFF38 (-200) -> out_ovf = 1, out_data = 8'h80 with the macro, 8'h38 without; input 32'hFFFFFF80 (-128) -> 8'h80 with out_ovf = 0.
REQ-036 Backpressure: stream words 1..10 with out_ready low for cycles 3-7 -> in_ready drops after 2 buffered words; all 10 emerge in order, none lost or duplicated.
REQ-037 Counter saturation: CNT_W = 4, 20 out-of-range words -> ovf_count holds at 15; clr_stats together with a further out-of-range word -> ovf_count = 0 and ovf_sticky = 0.
REQ-038 Reset mid-operation: rst_n low with 2 words buffered -> next cycle out_valid = 0, in_ready = 1, ovf_count = 0; no buffered word is ever emitted.
